fetch_queue_unit: RTL and testbench

- Parametrised instruction-fetch stage for the RISC-V core; next generation of the single-cycle PC / add4 / Mux_A fetch path.
- Owns the PC register and reads the combinational instruction memory.
- Buffers fetched instructions with their PCs in a QDEPTH-entry prefetch queue.
- Hands instructions to decode over a valid/ready handshake; accepts branch redirects (bne and later branch types) with queue flush.

---
 rtl/fetch_queue_unit.sv | 128 ++++++++++++
 tb/tb_fetch_queue_unit.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch stage: PC register, combinational imem read, prefetch queue to decode.
// Define FETCH_PERF_EN to add the redirect/stall performance counters.
module fetch_queue_unit #(
  parameter int unsigned            XLEN     = 32,
  parameter int unsigned            ILEN     = 32,
  parameter logic [XLEN-1:0]        RESET_PC = '0,
  parameter int unsigned            QDEPTH   = 4,
  parameter int unsigned            PC_STEP  = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] imem_addr,
  output logic            imem_en,
  input  logic [ILEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [ILEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic            fetch_err
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_redirects,
  output logic [31:0]     perf_stall_cycles
`endif
);

  localparam int unsigned PtrW = $clog2(QDEPTH);
  localparam int unsigned CntW = $clog2(QDEPTH) + 1;

  typedef enum logic [1:0] {StBoot, StRun, StErr} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [ILEN-1:0]   instr_mem [QDEPTH];
  logic [XLEN-1:0]   pc_mem [QDEPTH];
  logic              full, push, pop;

  assign full      = (count_q == CntW'(QDEPTH));
  assign id_valid  = (count_q != '0) && (state_q != StErr);
  assign id_instr  = id_valid ? instr_mem[rd_ptr_q] : '0;
  assign id_pc     = id_valid ? pc_mem[rd_ptr_q] : '0;
  assign imem_addr = fetch_pc_q;
  assign fetch_err = (state_q == StErr);
  assign push      = imem_en;
  assign pop       = id_valid && id_ready;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    imem_en    = 1'b0;

    unique case (state_q)
      StBoot:  state_d = StRun;
      StRun:   imem_en = !full && !redirect_valid;
      StErr:   ;
      default: state_d = StBoot;
    endcase

    if (push) begin
      wr_ptr_d   = wr_ptr_q + PtrW'(1);
      fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end

    // A redirect discards everything, including a head popped this same cycle.
    if (redirect_valid) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      fetch_pc_d = redirect_pc;
      state_d    = (redirect_pc[1:0] != 2'b00) ? StErr : StRun;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StBoot;
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= imem_rdata;
      pc_mem[wr_ptr_q]    <= fetch_pc_q;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_redirects    <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (redirect_valid && (perf_redirects != '1)) begin
        perf_redirects <= perf_redirects + 32'd1;
      end
      if (id_valid && !id_ready && (perf_stall_cycles != '1)) begin
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Self-checking bench for fetch_queue_unit against a queue-based reference model.
module tb_fetch_queue_unit;

  localparam int unsigned QDEPTH = 4;
  localparam logic [31:0] KEY    = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_addr;
  logic        imem_en;
  logic [31:0] imem_rdata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        fetch_err;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_redirects;
  logic [31:0] perf_stall_cycles;
`endif

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr ^ KEY;

  fetch_queue_unit #(.QDEPTH(QDEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_en        (imem_en),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .fetch_err      (fetch_err)
`ifdef FETCH_PERF_EN
    ,
    .perf_redirects    (perf_redirects),
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  // Reference model: mode 0=boot, 1=run, 2=error.
  ent_t        q[$];
  int          mode;
  logic [31:0] mpc;
  bit          known = 1'b0;
  logic [31:0] m_redirects, m_stalls;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic step(input bit r, input bit rv, input logic [31:0] rpc, input bit rdy);
    bit exp_valid, exp_en;
    @(negedge clk);
    rst            = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    id_ready       = rdy;
    #1;
    exp_valid = (q.size() != 0) && (mode != 2);
    exp_en    = (mode == 1) && (q.size() < QDEPTH) && !rv;
    if (known) begin
      chk("id_valid", 32'(id_valid), 32'(exp_valid));
      chk("imem_en", 32'(imem_en), 32'(exp_en));
      chk("fetch_err", 32'(fetch_err), 32'(mode == 2));
      chk("id_pc", id_pc, exp_valid ? q[0].pc : 32'h0);
      chk("id_instr", id_instr, exp_valid ? q[0].instr : 32'h0);
      if (exp_en) chk("imem_addr", imem_addr, mpc);
    end
    if (r) begin
      q.delete();
      mpc         = 32'h0;
      mode        = 0;
      m_redirects = '0;
      m_stalls    = '0;
      known       = 1'b1;
    end else begin
      if (rv && m_redirects != 32'hFFFF_FFFF) m_redirects++;
      if (exp_valid && !rdy && m_stalls != 32'hFFFF_FFFF) m_stalls++;
      if (rv) begin
        q.delete();
        mpc  = rpc;
        mode = (rpc[1:0] != 2'b00) ? 2 : 1;
      end else begin
        if (exp_valid && rdy) void'(q.pop_front());
        if (exp_en) begin
          q.push_back('{instr: mpc ^ KEY, pc: mpc});
          mpc = mpc + 32'd4;
        end
        if (mode == 0) mode = 1;
      end
    end
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, rdy);
  endtask

  initial begin
    step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    // Streaming from reset, then backpressure until full, then drain.
    idle(8, 1'b1);
    idle(10, 1'b0);
    chk("full_hold_pc", imem_addr, mpc);
    idle(6, 1'b1);
    // Three entries queued, then redirect while decode is accepting.
    step(1'b0, 1'b1, 32'h100, 1'b0);
    idle(3, 1'b0);
    chk("q_three", 32'(q.size()), 32'd3);
    step(1'b0, 1'b1, 32'h200, 1'b1);
    idle(4, 1'b1);
    // Misaligned redirect, hold in error, recover with an aligned one.
    step(1'b0, 1'b1, 32'h202, 1'b1);
    idle(5, 1'b1);
    step(1'b0, 1'b1, 32'h300, 1'b1);
    idle(4, 1'b1);
    // PC wrap at the top of the address space.
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    idle(4, 1'b1);
    // Reset with a full queue.
    idle(8, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    idle(5, 1'b1);
    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      bit          r, rv, rdy;
      logic [31:0] rpc;
      r   = ($urandom_range(0, 99) == 0);
      rv  = ($urandom_range(0, 15) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      rpc = $urandom;
      if ($urandom_range(0, 7) != 0) rpc[1:0] = 2'b00;
      step(r, rv, rpc, rdy);
    end
`ifdef FETCH_PERF_EN
    // Known counts: 3 redirects and 7 stalls after a fresh reset.
    step(1'b1, 1'b0, 32'h0, 1'b1);
    idle(3, 1'b1);
    idle(7, 1'b0);
    step(1'b0, 1'b1, 32'h40, 1'b1);
    step(1'b0, 1'b1, 32'h80, 1'b1);
    step(1'b0, 1'b1, 32'hC0, 1'b1);
    idle(1, 1'b1);
    chk("perf_redirects", perf_redirects, m_redirects);
    chk("perf_stalls", perf_stall_cycles, m_stalls);
    chk("perf_redirects_3", perf_redirects, 32'd3);
    chk("perf_stalls_7", perf_stall_cycles, 32'd7);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    idle(1, 1'b1);
    chk("perf_redirects_rst", perf_redirects, 32'd0);
    chk("perf_stalls_rst", perf_stall_cycles, 32'd0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
